// File: rtl/branch_resolve_if.sv
// branch_resolve_if: decode-candidate and fetch-redirect bundle for branch_resolve
//   master (decode/fetch side) drives in_valid, op, uncond, rs1_val, rs2_val, imm, pc, redir_ready
//   slave (branch_resolve) drives in_ready, redir_valid, redir_addr, redir_misalign, squash
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic            uncond;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_addr;
  logic            redir_misalign;
  logic            squash;
  modport master (
    output in_valid, op, uncond, rs1_val, rs2_val, imm, pc, redir_ready,
    input  in_ready, redir_valid, redir_addr, redir_misalign, squash
  );
  modport slave (
    input  in_valid, op, uncond, rs1_val, rs2_val, imm, pc, redir_ready,
    output in_ready, redir_valid, redir_addr, redir_misalign, squash
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: resolves a branch/jump, issues one fetch redirect, then squashes the shadow
//   clk, rst (sync, active-low); bif: branch_resolve_if.slave
//   BR_STATS_EN adds stat_branches / stat_taken (saturating accept counters)
module branch_resolve #(
  parameter int XLEN         = 32,
  parameter int SQUASH_DEPTH = 1,
  parameter int CHECK_ALIGN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bif
`ifdef BR_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_taken
`endif
);
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BGE  = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;
  localparam logic [3:0] OP_JAL  = 4'b1010;
  typedef enum logic [1:0] {IDLE, REDIR, SQUASH} state_t;
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d, jalr_sum, target;
  logic            mis_q, mis_d, eq, lt, ltu, taken, ready, accept;
  always_comb begin
    eq       = bif.rs1_val == bif.rs2_val;
    lt       = $signed(bif.rs1_val) < $signed(bif.rs2_val);
    ltu      = bif.rs1_val < bif.rs2_val;
    taken    = bif.uncond || (bif.op == OP_BEQ && eq) || (bif.op == OP_BNE && !eq) ||
               (bif.op == OP_BLT && lt) || (bif.op == OP_BGE && !lt) ||
               (bif.op == OP_BLTU && ltu) || (bif.op == OP_BGEU && !ltu);
    jalr_sum = bif.rs1_val + bif.imm;
    // uncond with any op other than JAL is JALR: register-relative, bit 0 cleared
    target   = (bif.uncond && bif.op != OP_JAL) ? (jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1})
                                                : bif.pc + bif.imm;
    ready    = rst && state_q == IDLE;
    accept   = bif.in_valid && ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    mis_d    = mis_q;
    case (state_q)
      IDLE: if (accept && taken) begin
        state_d = REDIR;
        addr_d  = target;
        mis_d   = CHECK_ALIGN != 0 && target[1:0] != 2'b00;
      end
      REDIR: if (bif.redir_ready) begin
        state_d = SQUASH;
        cnt_d   = 3'(SQUASH_DEPTH);
      end
      SQUASH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mis_q   <= mis_d;
    end
  end
  assign bif.in_ready       = ready;
  assign bif.redir_valid    = state_q == REDIR;
  assign bif.redir_addr     = addr_q;
  assign bif.redir_misalign = mis_q;
  assign bif.squash         = state_q != IDLE;
`ifdef BR_STATS_EN
  logic [31:0] br_q, tk_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_q <= '0;
      tk_q <= '0;
    end else begin
      if (accept && br_q != '1) br_q <= br_q + 32'd1;
      if (accept && taken && tk_q != '1) tk_q <= tk_q + 32'd1;
    end
  end
  assign stat_branches = br_q;
  assign stat_taken    = tk_q;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed scoreboard bench; u_a depth 1 / align check on, u_b depth 3 / align check off
module tb_branch_resolve;
  typedef struct packed {logic [3:0] op; logic u; logic [31:0] a, b, imm, pc;} vec_t;
  typedef struct packed {logic [31:0] addr; logic mis;} exp_t;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, in_valid, uncond, redir_ready;
  logic [3:0]  op;
  logic [31:0] rs1, rs2, imm, pc;
  int          npass = 0, nfail = 0, ntot = 0, n_acc = 0, n_tk = 0;
  bit          cur_align = 1'b1;
  exp_t        sb[$];
  vec_t        vt[$];
  branch_resolve_if #(.XLEN(32)) ifa();
  branch_resolve_if #(.XLEN(32)) ifb();
  assign ifa.in_valid = in_valid;
  assign ifa.op = op;
  assign ifa.uncond = uncond;
  assign ifa.rs1_val = rs1;
  assign ifa.rs2_val = rs2;
  assign ifa.imm = imm;
  assign ifa.pc = pc;
  assign ifa.redir_ready = redir_ready;
  assign ifb.in_valid = in_valid;
  assign ifb.op = op;
  assign ifb.uncond = uncond;
  assign ifb.rs1_val = rs1;
  assign ifb.rs2_val = rs2;
  assign ifb.imm = imm;
  assign ifb.pc = pc;
  assign ifb.redir_ready = redir_ready;
  always #5 clk = ~clk;
`ifdef BR_STATS_EN
  logic [31:0] stb_a, stt_a, stb_b, stt_b;
`endif
  branch_resolve #(.XLEN(32), .SQUASH_DEPTH(1), .CHECK_ALIGN(1)) u_a (
    .clk(clk), .rst(rst_a), .bif(ifa)
`ifdef BR_STATS_EN
    , .stat_branches(stb_a), .stat_taken(stt_a)
`endif
  );
  branch_resolve #(.XLEN(32), .SQUASH_DEPTH(3), .CHECK_ALIGN(0)) u_b (
    .clk(clk), .rst(rst_b), .bif(ifb)
`ifdef BR_STATS_EN
    , .stat_branches(stb_b), .stat_taken(stt_b)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic m_taken(input vec_t v);
    if (v.u) return 1'b1;
    case (v.op)
      4'b1000: return v.a == v.b;
      4'b1001: return v.a != v.b;
      4'b1100: return $signed(v.a) < $signed(v.b);
      4'b1101: return $signed(v.a) >= $signed(v.b);
      4'b1110: return v.a < v.b;
      4'b1111: return v.a >= v.b;
      default: return 1'b0;
    endcase
  endfunction
  function automatic exp_t m_exp(input vec_t v, input bit ca);
    logic [31:0] t;
    t = (v.u && v.op != 4'b1010) ? ((v.a + v.imm) & 32'hFFFF_FFFE) : v.pc + v.imm;
    return {t, ca && t[1:0] != 2'b00};
  endfunction
  task automatic cand(input vec_t v);
    in_valid = 1'b1;
    op = v.op;
    uncond = v.u;
    rs1 = v.a;
    rs2 = v.b;
    imm = v.imm;
    pc = v.pc;
    n_acc++;
    if (m_taken(v)) begin
      n_tk++;
      sb.push_back(m_exp(v, cur_align));
    end
  endtask
  task automatic pop_chk(input string tag, input logic [31:0] addr, input logic mis);
    exp_t e;
    chk({tag, "_pending"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_addr"}, addr, e.addr);
      chk({tag, "_mis"}, mis, e.mis);
    end
  endtask
  initial begin
    bit t;
    in_valid = 0; op = 0; uncond = 0; rs1 = 0; rs2 = 0; imm = 0; pc = 0;
    redir_ready = 0; rst_a = 0; rst_b = 0;
    vt.push_back('{4'b1000, 1'b0, 32'd5, 32'd5, 32'h20, 32'h100});
    vt.push_back('{4'b1001, 1'b0, 32'd5, 32'd5, 32'h20, 32'h100});
    vt.push_back('{4'b1001, 1'b0, 32'd5, 32'd6, 32'h8, 32'h104});
    vt.push_back('{4'b1100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200});
    vt.push_back('{4'b1110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200});
    vt.push_back('{4'b1101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200});
    vt.push_back('{4'b1101, 1'b0, 32'd1, 32'd1, 32'hFFFF_FFF0, 32'h100});
    vt.push_back('{4'b1111, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0});
    vt.push_back('{4'b1111, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h100});
    vt.push_back('{4'b0000, 1'b0, 32'd5, 32'd5, 32'h20, 32'h100});
    vt.push_back('{4'b1010, 1'b1, 32'd0, 32'd0, 32'h2, 32'h100});
    vt.push_back('{4'b0000, 1'b1, 32'h1003, 32'd0, 32'h0, 32'h500});
    vt.push_back('{4'b0110, 1'b1, 32'h1000, 32'd0, 32'h5, 32'h0});
    tick;
    tick;
    chk("rst_rdy_a", ifa.in_ready, 0);
    chk("rst_rdy_b", ifb.in_ready, 0);
    chk("rst_valid", ifa.redir_valid, 0);
    chk("rst_squash", ifa.squash, 0);
    chk("rst_addr", ifa.redir_addr, 0);
    chk("rst_mis", ifa.redir_misalign, 0);
    rst_a = 1;
    tick;
    chk("idle_rdy", ifa.in_ready, 1);
    redir_ready = 1;
    foreach (vt[i]) begin
      t = m_taken(vt[i]);
      cand(vt[i]);
      tick;
      in_valid = 0;
      if (t) begin
        chk($sformatf("v%0d_valid", i), ifa.redir_valid, 1);
        chk($sformatf("v%0d_sq0", i), ifa.squash, 1);
        chk($sformatf("v%0d_rdy0", i), ifa.in_ready, 0);
        pop_chk($sformatf("v%0d", i), ifa.redir_addr, ifa.redir_misalign);
        tick;
        chk($sformatf("v%0d_sqv", i), ifa.redir_valid, 0);
        chk($sformatf("v%0d_sq1", i), ifa.squash, 1);
        tick;
        chk($sformatf("v%0d_end_sq", i), ifa.squash, 0);
        chk($sformatf("v%0d_end_rdy", i), ifa.in_ready, 1);
      end else begin
        chk($sformatf("v%0d_nt_valid", i), ifa.redir_valid, 0);
        chk($sformatf("v%0d_nt_sq", i), ifa.squash, 0);
        chk($sformatf("v%0d_nt_rdy", i), ifa.in_ready, 1);
        chk($sformatf("v%0d_nt_sb", i), 64'(sb.size()), 0);
      end
    end
    redir_ready = 0;
    cand('{4'b1010, 1'b1, 32'd0, 32'd0, 32'h80, 32'h300});
    tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_valid", i), ifa.redir_valid, 1);
      chk($sformatf("hold%0d_addr", i), ifa.redir_addr, sb[0].addr);
      chk($sformatf("hold%0d_sq", i), ifa.squash, 1);
      chk($sformatf("hold%0d_rdy", i), ifa.in_ready, 0);
      in_valid = i[0];
      tick;
    end
    in_valid = 0;
    redir_ready = 1;
    chk("hold_last_valid", ifa.redir_valid, 1);
    pop_chk("hold", ifa.redir_addr, ifa.redir_misalign);
    tick;
    chk("hold_sq_valid", ifa.redir_valid, 0);
    chk("hold_sq", ifa.squash, 1);
    tick;
    chk("hold_end_sq", ifa.squash, 0);
    chk("hold_end_rdy", ifa.in_ready, 1);
    tick;
    chk("shadow_valid", ifa.redir_valid, 0);
    chk("shadow_sb", 64'(sb.size()), 0);
`ifdef BR_STATS_EN
    chk("stat_branches", stb_a, 64'(n_acc));
    chk("stat_taken", stt_a, 64'(n_tk));
`endif
    rst_a = 0;
    rst_b = 1;
    cur_align = 0;
    tick;
    cand('{4'b1000, 1'b0, 32'd5, 32'd5, 32'h10, 32'h400});
    tick;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("d3_sq%0d", i), ifb.squash, (i < 4) ? 1 : 0);
      chk($sformatf("d3_valid%0d", i), ifb.redir_valid, (i == 0) ? 1 : 0);
      if (i == 0) pop_chk("d3", ifb.redir_addr, ifb.redir_misalign);
      tick;
    end
    chk("d3_end_rdy", ifb.in_ready, 1);
    cand('{4'b0000, 1'b1, 32'h1003, 32'd0, 32'h0, 32'h0});
    tick;
    in_valid = 0;
    pop_chk("noalign", ifb.redir_addr, ifb.redir_misalign);
    tick;
    chk("rs_sq1", ifb.squash, 1);
    tick;
    chk("rs_sq2", ifb.squash, 1);
    rst_b = 0;
    tick;
    chk("rs_sq", ifb.squash, 0);
    chk("rs_valid", ifb.redir_valid, 0);
    chk("rs_rdy_low", ifb.in_ready, 0);
    rst_b = 1;
    tick;
    chk("rs_rdy", ifb.in_ready, 1);
    chk("rs_addr", ifb.redir_addr, 0);
    tick;
    chk("rs_residual", ifb.squash, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: datapath width, legal range 32..64.
REQ-002 The block SHALL have parameter SQUASH_DEPTH, default 1: cycles of younger-instruction squash after a redirect, legal range 1..7.
REQ-003 The block SHALL have parameter CHECK_ALIGN, default 1: when 1, flag redirect targets with target[1:0] != 0.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset: clk, rst.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  decode presents a branch/jump candidate.
- in_ready  out  1  block accepts the candidate this cycle.
- op  in  4  branch op: BEQ 1000, BNE 1001, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111, JAL 1010.
- uncond  in  1  unconditional jump; with op != JAL it means JALR.
- rs1_val, rs2_val  in  XLEN  operands.
- imm  in  XLEN  sign-extended immediate.
- pc  in  XLEN  instruction PC.
- redir_valid  out  1  redirect request to fetch.
- redir_ready  in  1  fetch accepts the redirect.
- redir_addr  out  XLEN  redirect target.
- redir_misalign  out  1  target misaligned, qualified by redir_valid.
- squash  out  1  kill the younger instruction in decode/EX this cycle.

Function
REQ-006 Taken SHALL be computed as follows: uncond -> 1; otherwise by op, with BLT/BGE signed and BLTU/BGEU unsigned; any other op -> 0.
REQ-007 Target SHALL be pc+imm when op==JAL or for a conditional branch, and {(rs1_val+imm)[XLEN-1:1],1'b0} for JALR; all sums SHALL be modulo 2^XLEN.
REQ-008 The FSM SHALL have states IDLE, REDIR, SQUASH; reset state SHALL be IDLE.
REQ-009 In IDLE, in_ready SHALL be 1; an accepted candidate that is not taken SHALL leave the FSM in IDLE with no outputs asserted.
REQ-010 In IDLE, an accepted taken candidate SHALL register target, misalign flag and state REDIR on the next edge (1-cycle latency from accept to redir_valid).
REQ-011 In REDIR, redir_valid SHALL be 1, and redir_addr/redir_misalign SHALL be held stable until redir_ready is sampled high.
REQ-012 A REDIR cycle with redir_ready=1 SHALL move the FSM to SQUASH and load the counter with SQUASH_DEPTH.
REQ-013 squash SHALL be 1 in every REDIR cycle and every SQUASH cycle.
REQ-014 In SQUASH, the counter SHALL decrement each cycle, and the FSM SHALL return to IDLE on the cycle the counter reaches 1, giving exactly SQUASH_DEPTH squash cycles after the handshake.
REQ-015 in_ready SHALL be 0 in REDIR and SQUASH; in_valid in those states SHALL be ignored and SHALL NOT be queued, since the candidate is a shadow instruction.
REQ-016 When CHECK_ALIGN=0, redir_misalign SHALL be constant 0.
REQ-017 A misaligned target SHALL still redirect; the flag SHALL be informational for the trap logic.

Reset
REQ-018 rst=0 at a rising edge SHALL force IDLE, counter 0, redir_valid 0, squash 0, redir_addr 0, redir_misalign 0, and in_ready 1 from the following cycle.
REQ-019 Reset mid-REDIR or mid-SQUASH SHALL abort the redirect and squash immediately, with no residual assertion.
REQ-020 in_ready SHALL be 0 while rst=0.

Configuration
REQ-021 The macro BR_STATS_EN SHALL compile in the statistics feature; without it the feature SHALL NOT exist.
REQ-022 With BR_STATS_EN defined, the block SHALL add 32-bit outputs stat_branches (accepted candidates) and stat_taken (accepted taken candidates).
REQ-023 The stat counters SHALL increment on accept, saturate at 0xFFFFFFFF, and clear on reset.
REQ-024 Without BR_STATS_EN, the block SHALL have no such ports and no counter logic.

Verification
REQ-025 BEQ, rs1=rs2=5, pc=0x100, imm=0x20, redir_ready=1 -> next cycle redir_valid=1, redir_addr=0x120, then squash for 1+SQUASH_DEPTH cycles total, then in_ready=1.
REQ-026 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken, FSM stays IDLE, squash=0.
REQ-027 JALR rs1=0x1003, imm=0 -> redir_addr=0x1002, redir_misalign=1 (CHECK_ALIGN=1); with CHECK_ALIGN=0 -> misalign=0.
REQ-028 Taken JAL with redir_ready held 0 for 4 cycles -> redir_valid and redir_addr stable for all 4 cycles, in_valid pulses ignored, SQUASH entered after the ready cycle.
REQ-029 rst=0 asserted in the second SQUASH cycle with SQUASH_DEPTH=3 -> next cycle squash=0, redir_valid=0, and after release in_ready=1.
REQ-030 BR_STATS_EN defined, 10 accepts with 4 taken -> stat_branches=10, stat_taken=4; shadow in_valid pulses not counted.
